// File: rtl/vram_copy_pkg.sv
// rtl/vram_copy_pkg.sv - shared state encoding and constants for the VRAM copy engine
package vram_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_COPY  = 3'd2,
        S_DRAIN = 3'd3,
        S_END   = 3'd4
    } state_t;

    localparam logic [12:0] VRAM_LAST_ADDR = 13'h12BF;
    localparam int          COPY_EN_BIT    = 0;

endpackage

// File: rtl/vram_copy_engine_if.sv
// rtl/vram_copy_engine_if.sv - front VRAM write port and back bus ownership flag
interface vram_copy_engine_if;

    logic [12:0] front_vram_addr;
    logic [7:0]  front_vram_data;
    logic        front_vram_wr_low;
    // High while the engine drives the shared back VRAM bus; gates the tristate drivers.
    logic        back_bus_owned;

    modport master (
        output front_vram_addr,
        output front_vram_data,
        output front_vram_wr_low,
        output back_bus_owned
    );

    modport slave (
        input front_vram_addr,
        input front_vram_data,
        input front_vram_wr_low,
        input back_bus_owned
    );

endinterface

// File: rtl/vblank_edge_det.sv
// rtl/vblank_edge_det.sv - registers vblank and flags its rising and falling edges
module vblank_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic vblank,
    output logic rise,
    output logic fall
);

    logic vblank_q;

    // Previous-cycle copy of vblank for edge comparison.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
        end
    end

    assign rise = vblank & ~vblank_q;
    assign fall = ~vblank & vblank_q;

endmodule

// File: rtl/vram_copy_engine.sv
// rtl/vram_copy_engine.sv - back-to-front VRAM copier started on vblank; optional abort via VRAM_COPY_OVERRUN_EN
module vram_copy_engine
    import vram_copy_pkg::*;
#(
    parameter logic [12:0] LAST_ADDR = VRAM_LAST_ADDR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          copy_enable,
    input  logic                vblank,
    output logic                copy_in_progress,
    output wire  [12:0]         back_vram_addr,
    output wire                 back_vram_rd_low,
    input  logic [7:0]          back_vram_data,
    output logic                copy_overrun,
    vram_copy_engine_if.master  vram
);

    state_t      state;
    state_t      next_state;
    logic [12:0] rd_cnt;
    logic        wr_valid;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        vblank_rise;
    logic        vblank_fall;
    logic        owned;
`ifdef VRAM_COPY_OVERRUN_EN
    logic        abort;
    logic        copy_done;
    logic        overrun_q;
`endif

    // Only bit 0 of the CPU register matters; the rest are don't-care.
    logic unused_enable_bits;
    assign unused_enable_bits = ^copy_enable;

    vblank_edge_det u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .vblank (vblank),
        .rise   (vblank_rise),
        .fall   (vblank_fall)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the enable bit is looked at only on the vblank rise.
    always_comb begin
        next_state = state;
`ifdef VRAM_COPY_OVERRUN_EN
        abort      = 1'b0;
        copy_done  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (vblank_rise && copy_enable[COPY_EN_BIT]) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                next_state = S_COPY;
`ifdef VRAM_COPY_OVERRUN_EN
                if (vblank_fall) begin
                    next_state = S_DRAIN;
                    abort      = 1'b1;
                end
`endif
            end
            S_COPY: begin
                // Reading the last byte wins over a coincident vblank fall: the copy is whole.
                if (rd_cnt == LAST_ADDR) begin
                    next_state = S_DRAIN;
`ifdef VRAM_COPY_OVERRUN_EN
                    copy_done  = 1'b1;
                end else if (vblank_fall) begin
                    next_state = S_DRAIN;
                    abort      = 1'b1;
`endif
                end
            end
            S_DRAIN: next_state = S_END;
            S_END:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign owned            = (state == S_COPY);
    assign copy_in_progress = (state == S_START) || (state == S_COPY) || (state == S_DRAIN);
    assign back_vram_addr   = owned ? rd_cnt : 13'bz;
    assign back_vram_rd_low = owned ? 1'b0 : 1'bz;

    // Read address counter; cleared in START and held at LAST_ADDR rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt <= 13'd0;
        end else if (state == S_START) begin
            rd_cnt <= 13'd0;
        end else if ((state == S_COPY) && (rd_cnt != LAST_ADDR)) begin
            rd_cnt <= rd_cnt + 13'd1;
        end
    end

    // One-stage write pipeline: the byte read this cycle is written to front VRAM next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_valid <= 1'b0;
            wr_addr  <= 13'd0;
            wr_data  <= 8'd0;
        end else begin
            wr_valid <= owned;
            if (owned) begin
                wr_addr <= rd_cnt;
                wr_data <= back_vram_data;
            end
        end
    end

    assign vram.front_vram_addr   = wr_addr;
    assign vram.front_vram_data   = wr_data;
    assign vram.front_vram_wr_low = ~wr_valid;
    assign vram.back_bus_owned    = owned;

`ifdef VRAM_COPY_OVERRUN_EN
    // Sticky overrun flag: set by an aborted copy, cleared by the next complete one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (abort) begin
            overrun_q <= 1'b1;
        end else if (copy_done) begin
            overrun_q <= 1'b0;
        end
    end

    assign copy_overrun = overrun_q;
`else
    logic unused_fall;
    assign unused_fall  = vblank_fall;
    assign copy_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_vram_copy_engine.sv
// tb/tb_vram_copy_engine.sv - randomized self-checking bench for vram_copy_engine
module tb_vram_copy_engine;

    localparam int NBYTES = 4800;
`ifdef VRAM_COPY_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  copy_enable = 8'h00;
    logic        vblank = 1'b0;
    logic        copy_in_progress;
    logic        copy_overrun;
    wire  [12:0] back_vram_addr;
    wire         back_vram_rd_low;
    logic [7:0]  back_vram_data;

    logic [7:0]  back_mem  [0:8191];
    logic [7:0]  front_mem [0:8191];

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int n_rd, n_wr, n_cip, order_err, first_rd_cyc, cip_first_cyc;
    bit model_overrun = 1'b0;

    vram_copy_engine_if vram();

    vram_copy_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .copy_enable      (copy_enable),
        .vblank           (vblank),
        .copy_in_progress (copy_in_progress),
        .back_vram_addr   (back_vram_addr),
        .back_vram_rd_low (back_vram_rd_low),
        .back_vram_data   (back_vram_data),
        .copy_overrun     (copy_overrun),
        .vram             (vram)
    );

    assign back_vram_data = back_mem[back_vram_addr];

    always #5 clk = ~clk;

    // Bus monitor: logs reads, front writes and busy cycles once per clock.
    always @(negedge clk) begin
        cycle++;
        if (vram.back_bus_owned && (back_vram_rd_low == 1'b0)) begin
            if (n_rd == 0) first_rd_cyc = cycle;
            if (back_vram_addr != 13'(n_rd)) order_err++;
            n_rd++;
        end
        if (!vram.front_vram_wr_low) begin
            front_mem[vram.front_vram_addr] = vram.front_vram_data;
            n_wr++;
        end
        if (copy_in_progress) begin
            if (n_cip == 0) cip_first_cyc = cycle;
            n_cip++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One vblank-triggered episode; events are indexed by clocks after vblank is raised.
    task automatic run_copy(input logic [7:0] ce, input int fall_at, input int repulse_at,
                            input int clr_at, input int rst_at, input bit fixed_ptn);
        int  exp_rd, exp_wr, exp_cip, front_bad, t0;
        bit  finished, aborted;
        logic [7:0] exp_byte;
        for (int a = 0; a < 8192; a++) begin
            back_mem[a]  = fixed_ptn ? (8'(a) ^ 8'h5A) : 8'($urandom);
            front_mem[a] = ~back_mem[a];
        end
        vblank = 1'b0;
        step(3);
        n_rd = 0; n_wr = 0; n_cip = 0; order_err = 0; first_rd_cyc = 0; cip_first_cyc = 0;
        copy_enable = ce;
        vblank = 1'b1;
        t0 = cycle;
        finished = 1'b0;
        for (int k = 1; k <= 6000 && !finished; k++) begin
            step(1);
            if (rst_at > 0 && k == rst_at + 1) begin
                check("rst_busy", copy_in_progress, 0);
                check("rst_bus_owned", vram.back_bus_owned, 0);
                check("rst_wr_low", vram.front_vram_wr_low, 1);
                check("rst_front_addr", vram.front_vram_addr, 0);
                check("rst_overrun", copy_overrun, 0);
                rst_n = 1'b1;
            end
            if (rst_at > 0 && k == rst_at) begin
                rst_n  = 1'b0;
                vblank = 1'b0;
            end
            if (k == fall_at) vblank = 1'b0;
            if (k == repulse_at) vblank = 1'b1;
            if (k == clr_at) copy_enable = 8'h00;
            if (k >= 50 && !copy_in_progress && rst_n) finished = 1'b1;
        end
        check("timeout", finished, 1);
        step(30);

        aborted = OVR_EN && ce[0] && (rst_at == 0) && (fall_at >= 2) && (fall_at <= NBYTES);
        if (!ce[0])          exp_rd = 0;
        else if (rst_at > 0) exp_rd = rst_at - 1;
        else if (aborted)    exp_rd = fall_at - 1;
        else                 exp_rd = NBYTES;
        exp_wr  = (ce[0] && rst_at > 0) ? rst_at - 2 : exp_rd;
        exp_cip = !ce[0] ? 0 : (rst_at > 0 ? rst_at : exp_rd + 2);
        if (rst_at > 0)  model_overrun = 1'b0;
        else if (ce[0])  model_overrun = aborted;

        check("reads", n_rd, exp_rd);
        check("read_order", order_err, 0);
        check("writes", n_wr, exp_wr);
        check("busy_cycles", n_cip, exp_cip);
        check("overrun", copy_overrun, model_overrun);
        if (ce[0]) check("busy_latency", cip_first_cyc - t0, 1);
        if (exp_rd > 0) check("first_read_latency", first_rd_cyc - t0, 2);
        front_bad = 0;
        for (int a = 0; a < 8192; a++) begin
            exp_byte = (a < exp_wr) ? back_mem[a] : ~back_mem[a];
            if (front_mem[a] !== exp_byte) front_bad++;
        end
        check("front_data", front_bad, 0);
        check("idle_busy", copy_in_progress, 0);
        check("idle_bus_owned", vram.back_bus_owned, 0);
        check("idle_wr_low", vram.front_vram_wr_low, 1);
        vblank = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        step(3);
        check("reset_busy", copy_in_progress, 0);
        check("reset_bus_owned", vram.back_bus_owned, 0);
        check("reset_wr_low", vram.front_vram_wr_low, 1);
        check("reset_front_addr", vram.front_vram_addr, 0);
        check("reset_front_data", vram.front_vram_data, 0);
        check("reset_overrun", copy_overrun, 0);
        rst_n = 1'b1;
        step(2);

        run_copy(8'h01, 0, 0, 0, 0, 1'b1);
        run_copy(8'($urandom) & 8'hFE, 0, 0, 0, 0, 1'b0);
        run_copy(8'($urandom) | 8'h01, 2000, 2001, 0, 0, 1'b0);
        run_copy(8'h01, 1000, 0, 0, 0, 1'b0);
        run_copy(8'($urandom) | 8'h01, 0, 0, 300, 0, 1'b0);
        run_copy(8'h01, int'($urandom_range(2, NBYTES)), 0, 0, 0, 1'b0);
        run_copy(8'h01, 0, 0, 0, 0, 1'b0);
        run_copy(8'h01, 0, 0, 0, 500, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
